// File: rtl/uart_transmitter_if.sv
// Byte-write handshake between the core-side debug logic and the UART transmitter.
interface uart_transmitter_if;
   logic       i_Tx_DV;
   logic [7:0] i_Tx_Byte;
   logic       o_Tx_Ready;

   modport master (output i_Tx_DV, output i_Tx_Byte, input  o_Tx_Ready);
   modport slave  (input  i_Tx_DV, input  i_Tx_Byte, output o_Tx_Ready);
endinterface

// File: rtl/uart_transmitter.sv
// Buffered 8N1 UART transmitter: small byte FIFO feeding a start/data/stop serialiser.
module uart_transmitter #(
   parameter int CLOCKS_PER_BIT  = 868,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic                i_Clock,
   input  logic                i_Reset_N,
   uart_transmitter_if.slave   tx_if,
   output logic                o_Tx_Serial,
   output logic                o_Tx_Active,
   output logic                o_Tx_Done,
   output logic                o_Fifo_Empty
);

   localparam int                     DEPTH    = 1 << FIFO_DEPTH_LOG2;
   localparam logic [FIFO_DEPTH_LOG2:0]   CNT_FULL = (FIFO_DEPTH_LOG2+1)'(DEPTH);
   localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE  = (FIFO_DEPTH_LOG2+1)'(1);
   localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);
   localparam logic [15:0]                CLK_LAST = 16'(CLOCKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_CLEANUP
   } state_t;

   state_t                     state_q;
   logic [7:0]                 fifo_q [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q;
   logic [FIFO_DEPTH_LOG2:0]   count_q;
   logic [FIFO_DEPTH_LOG2:0]   count_d;
   logic [7:0]                 shift_q;
   logic [15:0]                clk_cnt_q;
   logic [2:0]                 bit_idx_q;
   logic                       push;
   logic                       pop;
   logic                       bit_last;

   // Ready and empty come straight from the registered count; a same-edge pop
   // never frees a slot for a write on that edge.
   assign tx_if.o_Tx_Ready = (count_q != CNT_FULL);
   assign o_Fifo_Empty     = (count_q == '0);
   assign push             = tx_if.i_Tx_DV && tx_if.o_Tx_Ready;
   assign pop              = (state_q == S_IDLE) && (count_q != '0);
   assign bit_last         = (clk_cnt_q == CLK_LAST);

   // Occupancy update: simultaneous push and pop cancel out.
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (!push && pop) begin
         count_d = count_q - CNT_ONE;
      end
   end

   // FIFO pointers and count; pointers wrap naturally at the depth.
   always_ff @(posedge i_Clock or negedge i_Reset_N) begin
      if (!i_Reset_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         count_q <= count_d;
      end
   end

   // FIFO storage and shift register capture; pure data, no reset needed.
   always_ff @(posedge i_Clock) begin
      if (push) fifo_q[wr_ptr_q] <= tx_if.i_Tx_Byte;
      if (pop)  shift_q <= fifo_q[rd_ptr_q];
   end

   // Serialiser FSM; the line value for the next bit is set on the edge that
   // enters it, so every output is registered and aligned to the bit edges.
   always_ff @(posedge i_Clock or negedge i_Reset_N) begin
      if (!i_Reset_N) begin
         state_q     <= S_IDLE;
         o_Tx_Serial <= 1'b1;
         o_Tx_Done   <= 1'b0;
         o_Tx_Active <= 1'b0;
         clk_cnt_q   <= '0;
         bit_idx_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               o_Tx_Serial <= 1'b1;
               o_Tx_Done   <= 1'b0;
               bit_idx_q   <= '0;
               if (pop) begin
                  clk_cnt_q   <= '0;
                  o_Tx_Serial <= 1'b0;
                  o_Tx_Active <= 1'b1;
                  state_q     <= S_START;
               end
            end
            S_START: begin
               if (bit_last) begin
                  clk_cnt_q   <= '0;
                  bit_idx_q   <= '0;
                  o_Tx_Serial <= shift_q[0];
                  state_q     <= S_DATA;
               end else begin
                  clk_cnt_q <= clk_cnt_q + 16'd1;
               end
            end
            S_DATA: begin
               if (bit_last) begin
                  clk_cnt_q <= '0;
                  if (bit_idx_q == 3'd7) begin
                     o_Tx_Serial <= 1'b1;
                     state_q     <= S_STOP;
                  end else begin
                     bit_idx_q   <= bit_idx_q + 3'd1;
                     o_Tx_Serial <= shift_q[bit_idx_q + 3'd1];
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + 16'd1;
               end
            end
            S_STOP: begin
               if (bit_last) begin
                  clk_cnt_q   <= '0;
                  o_Tx_Done   <= 1'b1;
                  o_Tx_Active <= 1'b0;
                  state_q     <= S_CLEANUP;
               end else begin
                  clk_cnt_q <= clk_cnt_q + 16'd1;
               end
            end
            S_CLEANUP: begin
               o_Tx_Done <= 1'b0;
               state_q   <= S_IDLE;
            end
            default: begin
               o_Tx_Serial <= 1'b1;
               o_Tx_Done   <= 1'b0;
               o_Tx_Active <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomised bench for uart_transmitter with a frame-timing reference model.
module tb_uart_transmitter;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10*CPB + 2;

   logic clk;
   logic rst_n;
   logic tx_serial, tx_active, tx_done, fifo_empty;

   uart_transmitter_if tx_if ();

   uart_transmitter #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(2)) dut (
      .i_Clock      (clk),
      .i_Reset_N    (rst_n),
      .tx_if        (tx_if),
      .o_Tx_Serial  (tx_serial),
      .o_Tx_Active  (tx_active),
      .o_Tx_Done    (tx_done),
      .o_Fifo_Empty (fifo_empty)
   );

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;

   // Reference model: queue of accepted bytes plus the offset into the frame in flight.
   logic [7:0] m_q[$];
   bit         m_busy;
   int         m_off;
   logic [7:0] m_cur;
   bit         m_pushed;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_q.delete();
      m_busy   = 1'b0;
      m_off    = 0;
      m_pushed = 1'b0;
   endtask

   // One rising edge of the model: a frame lasts FRAME cycles from its pop edge,
   // the next pop needs a non-empty queue as seen before the edge.
   task automatic m_step();
      int pre;
      bit do_push;
      pre     = m_q.size();
      do_push = (tx_if.i_Tx_DV === 1'b1) && (pre != DEPTH);
      if (m_busy) begin
         m_off++;
         if (m_off == FRAME) m_busy = 1'b0;
      end
      if (!m_busy && pre > 0) begin
         m_cur  = m_q.pop_front();
         m_busy = 1'b1;
         m_off  = 0;
      end
      if (do_push) m_q.push_back(tx_if.i_Tx_Byte);
      m_pushed = do_push;
   endtask

   // Per-cycle comparison of all outputs against the model, #1 after each edge.
   initial begin
      logic e_ser, e_act, e_done;
      int   k;
      forever begin
         @(posedge clk);
         if (!rst_n) m_reset();
         else        m_step();
         #1;
         e_ser = 1'b1; e_act = 1'b0; e_done = 1'b0;
         if (m_busy) begin
            if (m_off < 10*CPB) begin
               e_act = 1'b1;
               k = m_off / CPB;
               if (k == 0)      e_ser = 1'b0;
               else if (k <= 8) e_ser = m_cur[k-1];
            end else if (m_off == 10*CPB) begin
               e_done = 1'b1;
            end
         end
         if (tx_done === 1'b1) done_cnt++;
         chk("serial", tx_serial,        e_ser);
         chk("active", tx_active,        e_act);
         chk("done",   tx_done,          e_done);
         chk("ready",  tx_if.o_Tx_Ready, (m_q.size() != DEPTH));
         chk("empty",  fifo_empty,       (m_q.size() == 0));
      end
   end

   // Present a byte and hold it until the model sees it accepted.
   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      tx_if.i_Tx_DV   = 1'b1;
      tx_if.i_Tx_Byte = b;
      do begin
         @(posedge clk); #2;
         n++;
      end while (!m_pushed && n < 2000);
      if (!m_pushed) chk("accept_bound", m_pushed, 1);
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         tx_if.i_Tx_DV = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      tx_if.i_Tx_DV = 1'b0;
      while ((m_busy || m_q.size() != 0) && n < 20000) begin
         @(posedge clk); #2;
         n++;
      end
      chk("drain_bound", (m_busy || m_q.size() != 0), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int n;
      logic [7:0] base;
      tx_if.i_Tx_DV   = 1'b0;
      tx_if.i_Tx_Byte = 8'h00;
      rst_n = 1'b1;
      m_reset();

      // Asynchronous reset before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("rst_serial", tx_serial,        1);
      chk("rst_ready",  tx_if.o_Tx_Ready, 1);
      chk("rst_empty",  fifo_empty,       1);
      chk("rst_done",   tx_done,          0);
      chk("rst_active", tx_active,        0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      gap(3);

      // Single byte
      d0 = done_cnt;
      send(8'hA5);
      drain();
      gap(2);
      chk("done_once", done_cnt - d0, 1);

      // Fill FIFO on consecutive cycles
      for (int i = 1; i <= 5; i++) send(8'(i));
      drain();
      gap(2);

      // Full FIFO backpressure
      send(8'h11);
      for (int i = 0; i < 4; i++) send(8'h21 + 8'(i));
      @(negedge clk);
      tx_if.i_Tx_DV   = 1'b1;
      tx_if.i_Tx_Byte = 8'hEE;
      @(posedge clk); #2;
      chk("full_ready", tx_if.o_Tx_Ready, 0);
      send(8'hEE);
      drain();
      gap(2);

      // Wrap-around with 10 distinct bytes
      base = 8'($urandom);
      for (int i = 0; i < 10; i++) begin
         send(base + 8'(i*37));
         gap($urandom_range(0, 2));
      end
      drain();
      chk("wrap_empty", fifo_empty, 1);

      // Random stream
      for (int i = 0; i < 25; i++) begin
         send(8'($urandom));
         gap($urandom_range(0, 6));
      end
      drain();
      gap(2);

      // Reset during data bit 3 with two bytes queued
      send(8'h30);
      send(8'hC3);
      send(8'h5A);
      @(negedge clk);
      tx_if.i_Tx_DV = 1'b0;
      n = 0;
      do begin
         @(posedge clk); #2;
         n++;
      end while (!(m_busy && m_off == 4*CPB + 1) && n < 2000);
      chk("midrst_reach", (m_busy && m_off == 4*CPB + 1), 1);
      chk("midrst_queued", m_q.size(), 2);
      rst_n = 1'b0;
      m_reset();
      #1;
      chk("midrst_serial", tx_serial,        1);
      chk("midrst_active", tx_active,        0);
      chk("midrst_done",   tx_done,          0);
      chk("midrst_empty",  fifo_empty,       1);
      chk("midrst_ready",  tx_if.o_Tx_Ready, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      d0 = done_cnt;
      gap(60);
      chk("post_rst_empty", fifo_empty, 1);
      chk("post_rst_nodone", done_cnt - d0, 0);
      chk("post_rst_line", tx_serial, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
